// File: rtl/usb_autodetect.sv
// usb_autodetect: passive USB bus-speed classifier in the ULPI (fe_clk) domain.
//
// After each restart the PHY is forced to the default FS/LS receive setup, the
// line is left to settle for I_wait1 cycles, and the idle linestate classifies
// the device as LS (K) or FS (J).  An FS device is then watched for the chirp-K
// / host K-J handshake that promotes it to HS, bounded by the I_wait2 timeout.
//
// Ports:
//   fe_clk, reset_i      clock, synchronous active-high reset
//   I_restart            single-cycle pulse, starts/restarts detection
//   I_wait1, I_wait2     settle time / HS-handshake timeout, in cycles
//   I_xcvrsel_default,
//   I_termsel_default    PHY setup applied during detection
//   I_linestate          ULPI linestate (00 SE0, 01 J, 10 K, 11 SE1)
//   O_usb_speed          detected speed (`USB_SPEED_HS/FS/LS)
//   O_xcvrsel, O_termsel PHY transceiver / termination select
//   O_busy, O_done       detection running / result final

`ifndef USB_SPEED_HS
`define USB_SPEED_HS 2'd0
`endif
`ifndef USB_SPEED_FS
`define USB_SPEED_FS 2'd1
`endif
`ifndef USB_SPEED_LS
`define USB_SPEED_LS 2'd2
`endif

module usb_autodetect #(
  parameter int pUSB_AUTO_COUNTER_WIDTH = 24,
  parameter int pCHIRP_MIN              = 150,
  parameter int pHS_PAIRS               = 3,
  parameter int pRUN_WIDTH              = 16
) (
  input  logic                               fe_clk,
  input  logic                               reset_i,
  input  logic                               I_restart,
  input  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait1,
  input  logic [pUSB_AUTO_COUNTER_WIDTH-1:0] I_wait2,
  input  logic [1:0]                         I_xcvrsel_default,
  input  logic                               I_termsel_default,
  input  logic [1:0]                         I_linestate,
  output logic [1:0]                         O_usb_speed,
  output logic [1:0]                         O_xcvrsel,
  output logic                               O_termsel,
  output logic                               O_busy,
  output logic                               O_done
);

  localparam int TW     = pUSB_AUTO_COUNTER_WIDTH;
  localparam int PAIR_W = (pHS_PAIRS < 2) ? 1 : $clog2(pHS_PAIRS + 1);

  localparam logic [TW-1:0]         T_ONE      = TW'(1);
  localparam logic [pRUN_WIDTH-1:0] RUN_ONE    = pRUN_WIDTH'(1);
  localparam logic [pRUN_WIDTH-1:0] CHIRP_MIN  = pRUN_WIDTH'(pCHIRP_MIN);
  localparam logic [PAIR_W-1:0]     PAIR_ONE   = PAIR_W'(1);
  localparam logic [PAIR_W-1:0]     PAIR_LAST  = PAIR_W'(pHS_PAIRS - 1);

  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_J   = 2'b01;
  localparam logic [1:0] LS_K   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CLASSIFY,
    S_HS_WAIT,
    S_HOST_CHIRP,
    S_DONE
  } state_t;

  state_t                  state;
  logic [TW-1:0]           timer;
  logic [pRUN_WIDTH-1:0]   run_cnt;
  logic [pRUN_WIDTH-1:0]   run_next;
  logic [1:0]              prev_ls;
  logic [PAIR_W-1:0]       pair_cnt;
  logic                    k_seen;
  logic                    wait1_hit;
  logic                    wait2_hit;
  logic                    run_qual;
  logic                    line_se;

  // run_next is the length of the current linestate run including this cycle,
  // so a segment qualifies exactly once, on the cycle it reaches pCHIRP_MIN.
  always_comb begin
    run_next = RUN_ONE;
    if (I_linestate == prev_ls) begin
      run_next = (run_cnt == '1) ? run_cnt : run_cnt + RUN_ONE;
    end
  end

  assign run_qual  = (run_next == CHIRP_MIN);
  assign line_se   = (I_linestate == LS_SE0) || (I_linestate == LS_SE1);
  assign wait1_hit = (I_wait1 == '0) || (timer == I_wait1 - T_ONE);
  assign wait2_hit = (timer == I_wait2 - T_ONE);

  always_ff @(posedge fe_clk) begin
    if (reset_i) begin
      state       <= S_IDLE;
      timer       <= '0;
      run_cnt     <= '0;
      prev_ls     <= LS_SE0;
      pair_cnt    <= '0;
      k_seen      <= 1'b0;
      O_usb_speed <= `USB_SPEED_FS;
      O_xcvrsel   <= 2'b01;
      O_termsel   <= 1'b1;
      O_busy      <= 1'b0;
      O_done      <= 1'b0;
    end else begin
      prev_ls <= I_linestate;
      run_cnt <= run_next;
      if (I_restart) begin
        state     <= S_SETTLE;
        timer     <= '0;
        pair_cnt  <= '0;
        k_seen    <= 1'b0;
        O_xcvrsel <= I_xcvrsel_default;
        O_termsel <= I_termsel_default;
        O_busy    <= 1'b1;
        O_done    <= 1'b0;
      end else begin
        case (state)
          S_IDLE: ;
          S_SETTLE: begin
            timer <= timer + T_ONE;
            if (wait1_hit) state <= S_CLASSIFY;
          end
          S_CLASSIFY: begin
            timer <= '0;
            case (I_linestate)
              LS_J: begin
                O_usb_speed <= `USB_SPEED_FS;
                state       <= S_HS_WAIT;
              end
              LS_K: begin
                O_usb_speed <= `USB_SPEED_LS;
                O_xcvrsel   <= 2'b10;
                O_busy      <= 1'b0;
                O_done      <= 1'b1;
                state       <= S_DONE;
              end
              default: state <= S_SETTLE;
            endcase
          end
          S_HS_WAIT: begin
            timer <= timer + T_ONE;
            if (wait2_hit) begin
              O_busy <= 1'b0;
              O_done <= 1'b1;
              state  <= S_DONE;
            end else if (I_linestate == LS_K && run_next >= CHIRP_MIN) begin
              // The device chirp K is itself a qualified K, so the first host
              // J can pair with it when the two K runs are contiguous.
              pair_cnt <= '0;
              k_seen   <= 1'b1;
              state    <= S_HOST_CHIRP;
            end
          end
          S_HOST_CHIRP: begin
            timer <= timer + T_ONE;
            if (I_linestate == LS_J && run_qual && k_seen && pair_cnt == PAIR_LAST) begin
              O_usb_speed <= `USB_SPEED_HS;
              O_xcvrsel   <= 2'b00;
              O_termsel   <= 1'b0;
              O_busy      <= 1'b0;
              O_done      <= 1'b1;
              state       <= S_DONE;
            end else if (wait2_hit) begin
              O_busy <= 1'b0;
              O_done <= 1'b1;
              state  <= S_DONE;
            end else if (line_se && run_qual) begin
              pair_cnt <= '0;
              k_seen   <= 1'b0;
              state    <= S_HS_WAIT;
            end else if (I_linestate == LS_K && run_qual) begin
              k_seen <= 1'b1;
            end else if (I_linestate == LS_J && run_qual && k_seen) begin
              pair_cnt <= pair_cnt + PAIR_ONE;
              k_seen   <= 1'b0;
            end
          end
          S_DONE: ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/usb_autodetect.md
# usb_autodetect

- Passive USB bus-speed classifier in the front-end (fe_clk, 60 MHz ULPI) domain.
- On each restart it:
  - forces the PHY to the default FS/LS receive configuration;
  - waits for the line to settle and classifies the device as LS or FS from the idle line state;
  - watches for the chirp-K / host K-J handshake that promotes FS to HS.
- It consumes the restart pulse, wait counts and PHY defaults from the USB register block (restart pulse already synchronized into fe_clk).
- It drives the PHY xcvrsel/termsel and the detected speed, which the register block reports to software.

## Interface
Parameters:
- pUSB_AUTO_COUNTER_WIDTH, 24: width of wait1/wait2 and the phase timer.
- pCHIRP_MIN, 150: minimum run length in cycles (2.5 us) for a chirp K or J segment to count.
- pHS_PAIRS, 3: host K-J pairs needed to declare HS.
- pRUN_WIDTH, 16: run-length counter width; must exceed clog2(pCHIRP_MIN).

Ports:
- Clock and reset: one clock, fe_clk; reset is synchronous and active-high, reset_i.
- fe_clk  in  1  ULPI clock; all logic on its rising edge.
- reset_i  in  1  synchronous, active-high.
- I_restart  in  1  single-cycle pulse; starts or restarts detection.
- I_wait1  in  pUSB_AUTO_COUNTER_WIDTH  settle time in cycles (default 60000 = 1 ms).
- I_wait2  in  pUSB_AUTO_COUNTER_WIDTH  HS-handshake timeout in cycles (default 3600000 = 60 ms).
- I_xcvrsel_default  in  2  xcvrsel applied during detection.
- I_termsel_default  in  1  termsel applied during detection.
- I_linestate  in  2  ULPI linestate, fe_clk-synchronous: 00 SE0, 01 J, 10 K, 11 SE1.
- O_usb_speed  out  2  detected speed, using the `USB_SPEED_HS/FS/LS codes.
- O_xcvrsel  out  2  PHY transceiver select.
- O_termsel  out  1  PHY termination select.
- O_busy  out  1  high while detection is running.
- O_done  out  1  high once a result is final; cleared by restart.

## Operation

Reset values:
- state IDLE; O_usb_speed = `USB_SPEED_FS; O_xcvrsel = 01; O_termsel = 1; O_busy = 0; O_done = 0.
- Timer and run counter are 0.

State machine:
- **IDLE**: outputs held. I_restart → SETTLE.
- **SETTLE**:
  - Entered with timer = 0, O_xcvrsel/O_termsel loaded from the defaults, O_busy = 1, O_done = 0.
  - Timer increments each cycle; when timer == I_wait1-1 (or I_wait1 == 0) → CLASSIFY.
- **CLASSIFY** (1 cycle; samples I_linestate):
  - 01 (J): O_usb_speed = FS; timer cleared; → HS_WAIT.
  - 10 (K): O_usb_speed = LS, O_xcvrsel = 10; → DONE.
  - 00 or 11: → SETTLE with timer cleared (retry; bus in reset or unstable).
- **HS_WAIT**: timer increments. If K is held for pCHIRP_MIN consecutive cycles (device chirp K) → HOST_CHIRP, pair count = 0.
- **HOST_CHIRP**:
  - The run counter tracks consecutive equal linestate.
  - A qualified segment is a J or K run of at least pCHIRP_MIN cycles.
  - Each qualified J that follows a qualified K increments the pair count.
  - Pair count reaching pHS_PAIRS: O_usb_speed = HS, O_xcvrsel = 00, O_termsel = 0; → DONE.
  - SE0/SE1 held for pCHIRP_MIN cycles → HS_WAIT with pair count cleared; timer not cleared.
- **Timeout**: in HS_WAIT or HOST_CHIRP, timer == I_wait2-1 → DONE; speed stays FS and the defaults stay applied.
- **DONE**: O_busy = 0, O_done = 1; outputs held until the next restart.

## Timing
- The run counter resets to 1 on any linestate change and saturates at all-ones.
- I_restart has priority in every state, including mid-SETTLE/HOST_CHIRP/DONE. The cycle after it: state SETTLE, O_busy = 1, O_done = 0, xcvrsel/termsel = defaults; O_usb_speed keeps its previous value until CLASSIFY.
- reset_i overrides I_restart.
- SETTLE lasts exactly max(I_wait1,1) cycles; CLASSIFY samples linestate on the cycle after.
- All outputs are registered: a decision in state S is visible the cycle after S.
- I_wait1/I_wait2 are compared live; a mid-run change whose new value is already passed lets the timer wrap modulo 2^width (no early exit).
- Timeout and the HS decision in the same cycle: HS wins.
- The chirp-K qualification and the timeout run from the same timer; the timer does not clear on the HS_WAIT↔HOST_CHIRP transition.

## Test plan
- Reset, then idle with no restart → speed FS, xcvrsel 01, termsel 1, busy 0, done 0 indefinitely.
- wait1 = 10, linestate 10, restart → busy for 10 cycles + CLASSIFY; then speed LS, xcvrsel 10, done 1.
- wait1 = 10, wait2 = 1000, linestate 01 constant → done after ~1011 cycles: speed FS, xcvrsel 01, termsel 1.
- HS handshake: after J classify, 200 cycles K, then 3×(200 K, 200 J) → speed HS, xcvrsel 00, termsel 0, done before the wait2 timeout.
- Short chirps: K and J runs of 100 cycles (< pCHIRP_MIN) → no promotion; times out as FS.
- Restart pulse mid-HOST_CHIRP → next cycle SETTLE, busy 1, done 0, defaults reapplied, pair count cleared.
- Linestate 00 at CLASSIFY → re-enters SETTLE; switching to 01 gives FS after a further wait1.
